seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned integer divider. It is the inverse of the multiplier path.
//  - Computes quotient = dividend / divisor and remainder = dividend % divisor.
//  - Uses a restoring shift-subtract loop that resolves one quotient bit per clock.
//  - Sits beside the adder/multiplier blocks as the arithmetic unit for division.
//  - Uses a simple start/busy/done handshake toward the controlling logic.

---
 rtl/seq_restoring_divider.sv | 143 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned divider using a restoring
// shift-subtract loop that resolves one quotient bit per clock.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         division request, accepted only when not running
//   dividend      numerator, sampled at the accepting edge
//   divisor       denominator, sampled at the accepting edge
//   busy          high while a division is in progress
//   done          one-cycle pulse, results valid in that cycle
//   quotient      result quotient, held until the next completion
//   remainder     result remainder, held until the next completion
//   div_by_zero   set with done when the divisor was zero
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_DONE_Z
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem_acc, rem_acc_nxt;
    logic [WIDTH-1:0] q_acc, q_acc_nxt;
    logic [WIDTH-1:0] dvsr, dvsr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quotient_nxt, remainder_nxt;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_iter;
    logic [WIDTH-1:0] q_iter;

    // One restoring iteration; trial MSB acts as the borrow (negative) flag
    always_comb begin
        shift_rem = {rem_acc, q_acc[WIDTH-1]};
        trial     = shift_rem - {1'b0, dvsr};
        q_iter    = {q_acc[WIDTH-2:0], ~trial[WIDTH]};
        rem_iter  = trial[WIDTH] ? shift_rem[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        rem_acc_nxt   = rem_acc;
        q_acc_nxt     = q_acc;
        dvsr_nxt      = dvsr;
        cnt_nxt       = cnt;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        dbz_nxt       = div_by_zero;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;

        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    rem_acc_nxt = '0;
                    q_acc_nxt   = dividend;
                    dvsr_nxt    = divisor;
                    cnt_nxt     = CNT_W'(WIDTH - 1);
                    busy_nxt    = 1'b1;
                    if (divisor == '0) begin
                        state_nxt = S_DONE_Z;
                    end else begin
                        state_nxt = S_RUN;
                        dbz_nxt   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                rem_acc_nxt = rem_iter;
                q_acc_nxt   = q_iter;
                if (cnt == '0) begin
                    state_nxt     = S_DONE;
                    done_nxt      = 1'b1;
                    quotient_nxt  = q_iter;
                    remainder_nxt = rem_iter;
                end else begin
                    busy_nxt = 1'b1;
                    cnt_nxt  = cnt - CNT_W'(1);
                end
            end
            S_DONE_Z: begin
                // Dividend still sits untouched in q_acc
                state_nxt     = S_DONE;
                done_nxt      = 1'b1;
                quotient_nxt  = '1;
                remainder_nxt = q_acc;
                dbz_nxt       = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rem_acc     <= '0;
            q_acc       <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_nxt;
            rem_acc     <= rem_acc_nxt;
            q_acc       <= q_acc_nxt;
            dvsr        <= dvsr_nxt;
            cnt         <= cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vector table plus hand-written corner
// sequences for the sequential restoring divider (WIDTH = 8).
module tb_seq_restoring_divider;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs [12];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at the cycle-1 negedge; returns the cycle index at which done is seen
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge with the DUT idle or in its done cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input int elat, input string name);
        int cyc;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'h5A;
        divisor  = 8'h00;
        check({name, "_busy_c1"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(elat));
        check({name, "_quotient"}, 32'(quotient), 32'(eq));
        check({name, "_remainder"}, 32'(remainder), 32'(er));
        check({name, "_dbz"}, 32'(div_by_zero), 32'(ez));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9};
        vecs[2]  = '{8'd3,   8'd10,  8'd0,   8'd3,  1'b0, 9};
        vecs[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9};
        vecs[4]  = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 2};
        vecs[5]  = '{8'd40,  8'd8,   8'd5,   8'd0,  1'b0, 9};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 9};
        vecs[7]  = '{8'd13,  8'd13,  8'd1,   8'd0,  1'b0, 9};
        vecs[8]  = '{8'd254, 8'd127, 8'd2,   8'd0,  1'b0, 9};
        vecs[9]  = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0, 9};
        vecs[10] = '{8'd0,   8'd0,   8'hFF,  8'd0,  1'b1, 2};
        vecs[11] = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0, 9};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                   vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Start pulsed mid-run must be ignored
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("ign_busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("ign_nodone_c%0d", c), 32'(done), 32'd0);
            if (c == 4) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_done_c9", 32'(done), 32'd1);
        check("ign_busy_c9", 32'(busy), 32'd0);
        check("ign_quotient", 32'(quotient), 32'd22);
        check("ign_remainder", 32'(remainder), 32'd2);
        @(negedge clk);
        check("ign_no_queue_busy", 32'(busy), 32'd0);
        check("ign_no_queue_done", 32'(done), 32'd0);

        // Back-to-back: new start in the done cycle of 60/7
        start = 1'b1; dividend = 8'd60; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_quotient", 32'(quotient), 32'd8);
        start = 1'b1; dividend = 8'd81; divisor = 8'd4;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next", 32'(busy), 32'd1);
        check("b2b_held_quotient", 32'(quotient), 32'd8);
        check("b2b_held_remainder", 32'(remainder), 32'd4);
        wait_done(cyc);
        check("b2b_latency", 32'(cyc), 32'd9);
        check("b2b_quotient", 32'(quotient), 32'd20);
        check("b2b_remainder", 32'(remainder), 32'd1);
        @(negedge clk);

        // Reset in cycle 3 of 99/3 aborts with no done
        start = 1'b1; dividend = 8'd99; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_op(8'd99, 8'd3, 8'd33, 8'd0, 1'b0, 9, "post_abort");

        // Random sweep with the division invariant
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            run_op(ra, rb, ra / rb, ra % rb, 1'b0, 9, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d_invariant", i),
                  32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            check($sformatf("rnd%0d_rem_lt_div", i), 32'(remainder < rb), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
